sent_rx_crc_scheduler: RTL

//  Shares the single SENT RX CRC check engine between the fast-channel frame decoder and the

---
 rtl/sent_rx_crc_scheduler.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sent_rx_crc_scheduler.sv
// sent_rx_crc_scheduler: arbitrates the shared SENT RX CRC check engine between the
// fast-channel decoder and the serial-message assembler, issues one command per
// request, returns pass/fail to the owner and keeps saturating error counters.
module sent_rx_crc_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk_rx,
  input  logic             reset_n_rx,
  input  logic             fast_req_i,
  input  logic [1:0]       fast_nib_sel_i,
  input  logic [29:0]      fast_data_i,
  output logic             fast_ack_o,
  output logic             fast_done_o,
  output logic             fast_crc_ok_o,
  input  logic             serial_req_i,
  input  logic             serial_enh_i,
  input  logic [29:0]      serial_data_i,
  output logic             serial_ack_o,
  output logic             serial_done_o,
  output logic             serial_crc_ok_o,
  output logic [2:0]       enable_crc_check_o,
  output logic [29:0]      data_check_crc_o,
  input  logic             crc_check_done_i,
  input  logic             valid_data_fast_i,
  input  logic             valid_data_serial_i,
  input  logic             valid_data_enhanced_i,
  input  logic             cnt_clr_i,
  output logic             busy_o,
  output logic             engine_fault_o,
  output logic [CNT_W-1:0] fast_err_cnt_o,
  output logic [CNT_W-1:0] serial_err_cnt_o
);

  localparam int unsigned DATA_W   = 30;
  localparam int unsigned CMD_W    = 3;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CMD_W-1:0] CMD_NONE = 3'b000;
  localparam logic [CMD_W-1:0] CMD_6NB  = 3'b001;
  localparam logic [CMD_W-1:0] CMD_4NB  = 3'b010;
  localparam logic [CMD_W-1:0] CMD_3NB  = 3'b011;
  localparam logic [CMD_W-1:0] CMD_SER  = 3'b100;
  localparam logic [CMD_W-1:0] CMD_ENH  = 3'b101;

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_SAMPLE  = 2'd2,
    S_RECOVER = 2'd3
  } state_e;

  state_e              state_q;
  logic                owner_serial_q;
  logic [CMD_W-1:0]    code_q;
  logic [CMD_W-1:0]    cmd_q;
  logic [DATA_W-1:0]   data_q;
  logic [STARVE_W-1:0] starve_q;
  logic                fast_ack_q;
  logic                serial_ack_q;
  logic                fast_done_q;
  logic                serial_done_q;
  logic                fast_ok_q;
  logic                serial_ok_q;
  logic                busy_q;
  logic                fault_q;
  logic [CNT_W-1:0]    fast_err_q;
  logic [CNT_W-1:0]    serial_err_q;

  logic                grant_fast_d;
  logic                grant_serial_d;
  logic [CMD_W-1:0]    grant_code_d;
  logic [DATA_W-1:0]   grant_data_d;
  logic                sample_ok_d;
  logic                fault_hit_d;
  logic                fast_inc_d;
  logic                serial_inc_d;

  // Arbitration and engine command code for a request seen in IDLE
  always_comb begin
    grant_fast_d   = 1'b0;
    grant_serial_d = 1'b0;
    grant_code_d   = CMD_NONE;
    grant_data_d   = fast_data_i;
    if (serial_req_i && (!fast_req_i || (starve_q == STARVE_MAX))) begin
      grant_serial_d = 1'b1;
    end else if (fast_req_i) begin
      grant_fast_d = 1'b1;
    end
    if (grant_serial_d) begin
      grant_code_d = serial_enh_i ? CMD_ENH : CMD_SER;
      grant_data_d = serial_data_i;
    end else begin
      unique case (fast_nib_sel_i)
        2'b00:   grant_code_d = CMD_3NB;
        2'b01:   grant_code_d = CMD_4NB;
        2'b10:   grant_code_d = CMD_6NB;
        default: grant_code_d = CMD_NONE;
      endcase
    end
  end

  // Engine result for the owner; a reserved fast code never passes and never faults
  always_comb begin
    sample_ok_d = 1'b0;
    fault_hit_d = 1'b0;
    if (owner_serial_q) begin
      sample_ok_d = (code_q == CMD_ENH) ? valid_data_enhanced_i : valid_data_serial_i;
    end else if (code_q != CMD_NONE) begin
      if (crc_check_done_i) begin
        sample_ok_d = valid_data_fast_i;
      end else begin
        fault_hit_d = 1'b1;
      end
    end
    fast_inc_d   = (state_q == S_SAMPLE) && !owner_serial_q && !sample_ok_d;
    serial_inc_d = (state_q == S_SAMPLE) && owner_serial_q && !sample_ok_d;
  end

  // Scheduler FSM with registered handshake, command and status outputs
  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      state_q        <= S_IDLE;
      owner_serial_q <= 1'b0;
      code_q         <= CMD_NONE;
      cmd_q          <= CMD_NONE;
      data_q         <= '0;
      starve_q       <= '0;
      fast_ack_q     <= 1'b0;
      serial_ack_q   <= 1'b0;
      fast_done_q    <= 1'b0;
      serial_done_q  <= 1'b0;
      fast_ok_q      <= 1'b0;
      serial_ok_q    <= 1'b0;
      busy_q         <= 1'b0;
      fault_q        <= 1'b0;
      fast_err_q     <= '0;
      serial_err_q   <= '0;
    end else begin
      fast_ack_q    <= 1'b0;
      serial_ack_q  <= 1'b0;
      fast_done_q   <= 1'b0;
      serial_done_q <= 1'b0;
      cmd_q         <= CMD_NONE;

      if (cnt_clr_i) begin
        fast_err_q   <= '0;
        serial_err_q <= '0;
      end else begin
        if (fast_inc_d && (fast_err_q != CNT_MAX)) begin
          fast_err_q <= fast_err_q + CNT_W'(1);
        end
        if (serial_inc_d && (serial_err_q != CNT_MAX)) begin
          serial_err_q <= serial_err_q + CNT_W'(1);
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (grant_fast_d || grant_serial_d) begin
            state_q        <= S_ISSUE;
            busy_q         <= 1'b1;
            owner_serial_q <= grant_serial_d;
            code_q         <= grant_code_d;
            cmd_q          <= grant_code_d;
            data_q         <= grant_data_d;
            fast_ack_q     <= grant_fast_d;
            serial_ack_q   <= grant_serial_d;
            if (grant_fast_d && serial_req_i) begin
              if (starve_q != STARVE_MAX) begin
                starve_q <= starve_q + STARVE_W'(1);
              end
            end else begin
              starve_q <= '0;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          state_q <= S_RECOVER;
          if (fault_hit_d) begin
            fault_q <= 1'b1;
          end
          if (owner_serial_q) begin
            serial_done_q <= 1'b1;
            serial_ok_q   <= sample_ok_d;
          end else begin
            fast_done_q <= 1'b1;
            fast_ok_q   <= sample_ok_d;
          end
        end
        S_RECOVER: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fast_ack_o         = fast_ack_q;
  assign fast_done_o        = fast_done_q;
  assign fast_crc_ok_o      = fast_ok_q;
  assign serial_ack_o       = serial_ack_q;
  assign serial_done_o      = serial_done_q;
  assign serial_crc_ok_o    = serial_ok_q;
  assign enable_crc_check_o = cmd_q;
  assign data_check_crc_o   = data_q;
  assign busy_o             = busy_q;
  assign engine_fault_o     = fault_q;
  assign fast_err_cnt_o     = fast_err_q;
  assign serial_err_cnt_o   = serial_err_q;

endmodule
